// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the 5x5 convolution window engine.
//   state_e    - engine FSM states (IDLE, RUN, DRAIN)
//   acc_width  - accumulator width that holds n*n products of a d-bit unsigned
//                pixel and a w-bit signed weight without overflow
//   result_t   - {data, y, x} result record for the default geometry
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One product is d+w+1 bits (pixel gains a zero sign bit); summing n*n of
  // them needs clog2(n*n) more bits.
  function automatic int acc_width(input int d, input int w, input int n);
    return d + w + 1 + $clog2(n * n);
  endfunction

  localparam int RES_DATA_W  = acc_width(16, 8, 5);
  localparam int RES_COORD_W = 5;

  typedef struct packed {
    logic signed [RES_DATA_W-1:0] data;
    logic [RES_COORD_W-1:0]       y;
    logic [RES_COORD_W-1:0]       x;
  } result_t;

endpackage

// File: rtl/conv_out_fifo.sv
// conv_out_fifo: synchronous FIFO for convolution results.
//   clk, rst_n           - clock, synchronous active-low reset (empties FIFO)
//   push, push_data      - write strobe and payload
//   pop, pop_data        - read strobe and head payload (0 while empty)
//   count, full, empty   - occupancy status
// Push and pop in the same cycle are accepted even when full.
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/conv5x5_window_engine.sv
// conv5x5_window_engine: scans every 5x5 window origin of a tile, reads the
// window from the interleaved window RAM, convolves it with a loaded signed
// kernel and streams one result per origin in raster order.
//   clk, rst_n            - clock, synchronous active-low reset
//   start / busy / done   - scan control and status
//   w_we, w_addr, w_data  - kernel load (IDLE only, index r*I_WIDTH+c)
//   addrb_y, addrb_x, re  - window RAM read port (data returns 2 cycles later)
//   win                   - window, pixel (r,c) at bits [(r*I_WIDTH+c)*D_SIZE +: D_SIZE]
//   out_valid/out_ready   - result handshake; out_data, out_y, out_x payload
// Build option: define CONV_RELU_EN to clamp negative sums to zero before the
// FIFO; otherwise the raw signed sum is output. FIFO_DEPTH must be >= 5.
module conv5x5_window_engine
  import conv_pkg::*;
#(
  parameter int  I_WIDTH    = 5,
  parameter int  T_WIDTH    = 32,
  parameter int  D_SIZE     = 16,
  parameter int  W_SIZE     = 8,
  parameter int  FIFO_DEPTH = 8,
  localparam int T_LOG      = $clog2(T_WIDTH),
  localparam int ACC_W      = acc_width(D_SIZE, W_SIZE, I_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  input  logic                              w_we,
  input  logic [4:0]                        w_addr,
  input  logic [W_SIZE-1:0]                 w_data,
  output logic [T_LOG-1:0]                  addrb_y,
  output logic [T_LOG-1:0]                  addrb_x,
  output logic                              re,
  input  logic [I_WIDTH*I_WIDTH*D_SIZE-1:0] win,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_W-1:0]                  out_data,
  output logic [T_LOG-1:0]                  out_y,
  output logic [T_LOG-1:0]                  out_x
);
  localparam int N     = I_WIDTH * I_WIDTH;
  localparam int P_W   = D_SIZE + W_SIZE + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PAY_W = ACC_W + 2 * T_LOG;
  localparam logic [T_LOG-1:0] O_LAST = T_LOG'(T_WIDTH - I_WIDTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]               state;
  logic [T_LOG-1:0]         oy, ox;
  logic [CNT_W-1:0]         inflight, fifo_count;
  logic signed [W_SIZE-1:0] weight [N];

  // Coordinate tags travel alongside the data; stage s is valid s cycles
  // after the issue. Stage 4 lines up with the registered sum.
  logic [4:1]               tag_v;
  logic [T_LOG-1:0]         tag_y [1:4];
  logic [T_LOG-1:0]         tag_x [1:4];

  logic signed [P_W-1:0]    prod_d [N];
  logic signed [P_W-1:0]    prod_q [N];
  logic signed [ACC_W-1:0]  sum_d, sum_q, push_data;
  logic                     issue, push, pop, fifo_full, fifo_empty;
  logic [PAY_W-1:0]         head;

  // Credit check covers both queued and in-flight results, so the FIFO can
  // never be asked to accept more than it holds.
  assign issue     = (state == S_RUN) && (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
  assign push      = tag_v[4];
  assign pop       = out_valid && out_ready;
  assign re        = issue;
  assign addrb_y   = oy;
  assign addrb_x   = ox;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DRAIN) && (inflight == '0) && fifo_empty;
  assign out_valid = !fifo_empty;
  assign {out_data, out_y, out_x} = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      oy       <= '0;
      ox       <= '0;
      inflight <= '0;
      for (int k = 0; k < N; k++) weight[k] <= '0;
    end else begin
      inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            oy    <= '0;
            ox    <= '0;
          end
          if (w_we && int'(w_addr) < N) weight[w_addr] <= w_data;
        end
        S_RUN: begin
          if (issue) begin
            if (ox == O_LAST && oy == O_LAST) begin
              state <= S_DRAIN;
            end else if (ox == O_LAST) begin
              ox <= '0;
              oy <= oy + T_LOG'(1);
            end else begin
              ox <= ox + T_LOG'(1);
            end
          end
        end
        S_DRAIN: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tag_v <= '0;
    else        tag_v <= {tag_v[3:1], issue};
  end

  always_ff @(posedge clk) begin
    tag_y[1] <= oy;
    tag_x[1] <= ox;
    for (int s = 2; s <= 4; s++) begin
      tag_y[s] <= tag_y[s-1];
      tag_x[s] <= tag_x[s-1];
    end
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  // Pixels are unsigned: a zero top bit makes them non-negative signed values.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      prod_d[k] = P_W'($signed({1'b0, win[k*D_SIZE +: D_SIZE]})) * P_W'(weight[k]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
  end

  always_comb begin
`ifdef CONV_RELU_EN
    push_data = sum_q[ACC_W-1] ? '0 : sum_q;
`else
    push_data = sum_q;
`endif
  end

  conv_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_data, tag_y[4], tag_x[4]}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_conv5x5_window_engine.sv
module tb_conv5x5_window_engine;
  localparam int TW   = 32;
  localparam int OW   = 28;
  localparam int NRES = OW * OW;
`ifdef CONV_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, w_we, re, busy, done, out_valid, out_ready;
  logic [4:0]  w_addr, addrb_y, addrb_x, out_y, out_x;
  logic [7:0]  w_data;
  logic [399:0] win;
  logic [29:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] pix [TW][TW];
  int          wm  [25];
  logic [9:0]  a1, a2;

  typedef struct {
    int     pix;
    int     wt;
    longint exp;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;

  conv5x5_window_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .addrb_y   (addrb_y),
    .addrb_x   (addrb_x),
    .re        (re),
    .win       (win),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_y     (out_y),
    .out_x     (out_x)
  );

  // Window RAM: returns the window two cycles after the read address.
  always @(posedge clk) begin
    a1 <= {addrb_y, addrb_x};
    a2 <= a1;
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        win[(r*5+c)*16 +: 16] = pix[(int'(a2[9:5]) + r) % TW][(int'(a2[4:0]) + c) % TW];
  end

  function automatic longint ref_val(input int y, input int x);
    longint s = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        s += longint'(pix[(y + r) % TW][(x + c) % TW]) * wm[r*5+c];
    if (RELU && s < 0) s = 0;
    return s;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fill_uniform(input int p);
    for (int y = 0; y < TW; y++)
      for (int x = 0; x < TW; x++) pix[y][x] = 16'(p);
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < TW; y++)
      for (int x = 0; x < TW; x++) pix[y][x] = 16'(y * 32 + x);
  endtask

  task automatic fill_random();
    for (int y = 0; y < TW; y++)
      for (int x = 0; x < TW; x++) pix[y][x] = 16'($urandom);
  endtask

  // mode 0: all weights = val; 1: only centre tap = val; 2: random.
  // Addresses 25..31 get junk that the DUT must ignore.
  task automatic load_weights(input int mode, input int val);
    for (int k = 0; k < 32; k++) begin
      int v;
      case (mode)
        0:       v = val;
        1:       v = (k == 12) ? val : 0;
        default: v = int'($urandom_range(255)) - 128;
      endcase
      if (k < 25) wm[k] = v;
      else        v = -77;
      w_we   = 1'b1;
      w_addr = 5'(k);
      w_data = 8'(v);
      @(negedge clk);
    end
    w_we = 1'b0;
    @(negedge clk);
  endtask

  // cmode 0: reference model; 1: constant cexp; 2: centre-tap ramp formula.
  task automatic run_scan(input string name, input int ready_pct, input int cmode,
                          input longint cexp, input int hold_at, input bit disturb);
    int n_res = 0, n_iss = 0, n_done = 0, cyc = 0;
    int last_pop = -1, done_at = -1, first_re = -1, first_ov = -1, max_out = 0;
    longint expv;
    int ey, ex;
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy after start"}, busy, 1);
    while (cyc < 6000 && !(done_at >= 0 && cyc > done_at + 3)) begin
      if (hold_at > 0 && cyc >= hold_at && cyc < hold_at + 100) out_ready = 1'b0;
      else out_ready = ($urandom_range(99) < ready_pct);
      if (disturb) begin
        start  = (cyc == 20);
        w_we   = (cyc >= 30 && cyc < 35);
        w_addr = 5'd12;
        w_data = 8'd77;
      end
      if (re) begin
        if (first_re < 0) first_re = cyc;
        chk({name, " read addr"}, addrb_y * 32 + addrb_x, (n_iss / OW) * 32 + (n_iss % OW));
        n_iss++;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        ey = n_res / OW;
        ex = n_res % OW;
        case (cmode)
          1:       expv = cexp;
          2:       expv = (ey + 2) * 32 + (ex + 2);
          default: expv = (n_res < NRES) ? ref_val(ey, ex) : -1;
        endcase
        chk({name, " coord"}, out_y * 32 + out_x, ey * 32 + ex);
        chk({name, " data"}, longint'($signed(out_data)), expv);
        last_pop = cyc;
        n_res++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (n_iss - n_res > max_out) max_out = n_iss - n_res;
      if (hold_at > 0 && cyc == hold_at + 99) begin
        chk({name, " re low when credits used"}, re, 0);
        chk({name, " outstanding at stall"}, n_iss - n_res, 8);
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    w_we      = 1'b0;
    chk({name, " result count"}, n_res, NRES);
    chk({name, " issue count"}, n_iss, NRES);
    chk({name, " done pulses"}, n_done, 1);
    chk({name, " done after last pop"}, done_at - last_pop, 1);
    chk({name, " first result latency"}, first_ov - first_re, 5);
    chk({name, " outstanding bound"}, (max_out <= 8) ? 1 : 0, 1);
    chk({name, " busy idle"}, busy, 0);
    chk({name, " out_valid idle"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
    for (int k = 0; k < 25; k++) wm[k] = 0;
    fill_uniform(0);
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset re", re, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset addrb_y", addrb_y, 0);
    chk("reset addrb_x", addrb_x, 0);
    chk("reset out_y", out_y, 0);
    chk("reset out_x", out_x, 0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{3,     1,    75};
    tbl[1] = '{65535, -128, RELU ? 0 : -(65535 * 128 * 25)};
    tbl[2] = '{0,     127,  0};
    tbl[3] = '{1,     -1,   RELU ? 0 : -25};
    tbl[4] = '{65535, 127,  65535 * 127 * 25};
    for (int i = 0; i < 5; i++) begin
      fill_uniform(tbl[i].pix);
      load_weights(0, tbl[i].wt);
      run_scan($sformatf("uniform%0d", i), (i == 0) ? 100 : 70, 1, tbl[i].exp, 0, 1'b0);
    end

    fill_ramp();
    load_weights(1, 1);
    run_scan("centre_tap", 75, 2, 0, 0, 1'b0);

    fill_random();
    load_weights(2, 0);
    run_scan("backpressure", 100, 0, 0, 50, 1'b0);

    fill_uniform(3);
    load_weights(0, 1);
    run_scan("ignored_inputs", 90, 1, 75, 0, 1'b1);

    fill_random();
    load_weights(2, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      out_ready = 1'($urandom_range(1));
      @(negedge clk);
    end
    chk("midrun busy", busy, 1);
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrun reset out_valid", out_valid, 0);
    chk("midrun reset busy", busy, 0);
    chk("midrun reset re", re, 0);
    chk("midrun reset done", done, 0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) wm[k] = 0;
    @(negedge clk);
    load_weights(2, 0);
    run_scan("after_reset", 60, 0, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
